// File: rtl/gc_arb_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gc_arb_n: N-channel arbiter for host good-completion pointer updates.       |
// | Round-robin or fixed priority, enable mask, idle gap, ack timeout, counter. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gc_arb_n #(
  parameter int NCH     = 4,
  parameter int AW      = 64,
  parameter int CW      = 2,
  parameter int RR      = 1,
  parameter int MIN_GAP = 0,
  parameter int TMO     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    ch_en,
  input  logic [NCH*AW-1:0] gc_addr_in,
  input  logic [NCH-1:0]    gc_updt_in,
  output logic [NCH-1:0]    gc_updt_ack_out,
  output logic [AW-1:0]     gc_addr,
  output logic              gc_updt,
  input  logic              gc_updt_ack,
  output logic [CW-1:0]     gc_grant_id,
  output logic [31:0]       upd_cnt,
  output logic              tmo_err
);

  localparam logic [3:0]  c_GAP_LOAD = 4'((MIN_GAP > 0) ? (MIN_GAP - 1) : 0);
  localparam logic [31:0] c_TMO      = 32'(TMO);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [AW-1:0]      r_addr, w_addr_nxt;
  logic [CW-1:0]      r_id, w_id_nxt;
  logic               r_updt, w_updt_nxt;
  logic [NCH-1:0]     r_ack, w_ack_nxt;
  logic [31:0]        r_cnt, w_cnt_nxt;
  logic               r_err, w_err_nxt;
  logic [CW-1:0]      r_rr_ptr, w_ptr_nxt;
  logic [3:0]         r_gap_cnt, w_gap_nxt;
  logic [31:0]        r_tmo_cnt, w_tmo_nxt;

  logic [NCH-1:0]     w_elig;
  logic [NCH-1:0]     w_hi;
  logic               w_win_vld;
  logic [CW-1:0]      w_win_id;
  logic [AW-1:0]      w_win_addr;
  logic               w_arb;

  // The channel being acked still holds its request for this cycle.
  assign w_elig = gc_updt_in & ch_en & ~r_ack;

  always_comb begin
    w_hi      = '0;
    w_win_vld = |w_elig;
    w_win_id  = '0;
    for (int k = 0; k < NCH; k++) begin
      w_hi[k] = w_elig[k] && (k >= int'(r_rr_ptr));
    end
    for (int k = NCH-1; k >= 0; k--) begin
      if (w_elig[k]) w_win_id = CW'(k);
    end
    // Round-robin prefers the lowest eligible at/after the pointer, else wraps.
    if (RR != 0 && |w_hi) begin
      for (int k = NCH-1; k >= 0; k--) begin
        if (w_hi[k]) w_win_id = CW'(k);
      end
    end
  end

  assign w_win_addr = gc_addr_in[int'(w_win_id)*AW +: AW];

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_id_nxt    = r_id;
    w_updt_nxt  = r_updt;
    w_ack_nxt   = '0;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_ptr_nxt   = r_rr_ptr;
    w_gap_nxt   = r_gap_cnt;
    w_tmo_nxt   = r_tmo_cnt;
    w_arb       = 1'b0;
    case (r_state)
      S_IDLE: w_arb = 1'b1;
      S_BUSY: begin
        if (gc_updt_ack) begin
          w_updt_nxt      = 1'b0;
          w_ack_nxt[r_id] = 1'b1;
          w_cnt_nxt       = r_cnt + 32'd1;
          w_ptr_nxt       = (int'(r_id) == NCH-1) ? '0 : r_id + CW'(1);
          if (MIN_GAP > 0) begin
            w_state_nxt = S_GAP;
            w_gap_nxt   = c_GAP_LOAD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          if (r_tmo_cnt != c_TMO) w_tmo_nxt = r_tmo_cnt + 32'd1;
          if (TMO > 0 && (r_tmo_cnt + 32'd1) == c_TMO) w_err_nxt = 1'b1;
        end
      end
      // Last gap cycle may grant, so exactly MIN_GAP idle cycles separate grants.
      S_GAP: begin
        if (r_gap_cnt == 4'd0) w_arb = 1'b1;
        else                   w_gap_nxt = r_gap_cnt - 4'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_arb) begin
      if (w_win_vld) begin
        w_state_nxt = S_BUSY;
        w_addr_nxt  = w_win_addr;
        w_id_nxt    = w_win_id;
        w_updt_nxt  = 1'b1;
        w_tmo_nxt   = '0;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_id      <= '0;
      r_updt    <= 1'b0;
      r_ack     <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_rr_ptr  <= '0;
      r_gap_cnt <= '0;
      r_tmo_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_id      <= w_id_nxt;
      r_updt    <= w_updt_nxt;
      r_ack     <= w_ack_nxt;
      r_cnt     <= w_cnt_nxt;
      r_err     <= w_err_nxt;
      r_rr_ptr  <= w_ptr_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_tmo_cnt <= w_tmo_nxt;
    end
  end

  assign gc_updt_ack_out = r_ack;
  assign gc_addr         = r_addr;
  assign gc_updt         = r_updt;
  assign gc_grant_id     = r_id;
  assign upd_cnt         = r_cnt;
  assign tmo_err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gc_arb_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gc_arb_n: two arbiter configurations against a behavioural model.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_gc_arb_n;

  localparam int NCH = 4;
  localparam int AW  = 64;
  localparam int CW  = 2;
  localparam int NI  = 2;
  localparam int RR_A = 1, GAP_A = 3, TMO_A = 16;
  localparam int RR_B = 0, GAP_B = 0, TMO_B = 0;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    ch_en;
  logic [NCH*AW-1:0] gc_addr_in;
  logic [NCH-1:0]    gc_updt_in;
  logic              gc_updt_ack;

  logic [NCH-1:0] a_ack_out, b_ack_out;
  logic [AW-1:0]  a_addr, b_addr;
  logic           a_updt, b_updt;
  logic [CW-1:0]  a_id, b_id;
  logic [31:0]    a_cnt, b_cnt;
  logic           a_err, b_err;

  int total;
  int bad;

  always #5 clk = ~clk;

  gc_arb_n #(.NCH(NCH), .AW(AW), .CW(CW), .RR(RR_A), .MIN_GAP(GAP_A), .TMO(TMO_A)) u_dut_a (
    .clk(clk), .rst(rst), .ch_en(ch_en), .gc_addr_in(gc_addr_in), .gc_updt_in(gc_updt_in),
    .gc_updt_ack_out(a_ack_out), .gc_addr(a_addr), .gc_updt(a_updt), .gc_updt_ack(gc_updt_ack),
    .gc_grant_id(a_id), .upd_cnt(a_cnt), .tmo_err(a_err)
  );

  gc_arb_n #(.NCH(NCH), .AW(AW), .CW(CW), .RR(RR_B), .MIN_GAP(GAP_B), .TMO(TMO_B)) u_dut_b (
    .clk(clk), .rst(rst), .ch_en(ch_en), .gc_addr_in(gc_addr_in), .gc_updt_in(gc_updt_in),
    .gc_updt_ack_out(b_ack_out), .gc_addr(b_addr), .gc_updt(b_updt), .gc_updt_ack(gc_updt_ack),
    .gc_grant_id(b_id), .upd_cnt(b_cnt), .tmo_err(b_err)
  );

  // Reference state: what each arbiter should present after every edge.
  bit             m_busy[NI];
  int             m_id[NI];
  logic [AW-1:0]  m_addr[NI];
  logic [NCH-1:0] m_ack[NI];
  logic [31:0]    m_cnt[NI];
  bit             m_err[NI];
  int             m_ptr[NI];
  int             m_k[NI];     // index of current idle cycle since the last ack
  int             m_bcyc[NI];  // edges spent waiting in the current grant

  function automatic int cfg_rr(int i);  return (i == 0) ? RR_A  : RR_B;  endfunction
  function automatic int cfg_gap(int i); return (i == 0) ? GAP_A : GAP_B; endfunction
  function automatic int cfg_tmo(int i); return (i == 0) ? TMO_A : TMO_B; endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_busy[i] = 1'b0; m_id[i] = 0; m_addr[i] = '0; m_ack[i] = '0;
      m_cnt[i] = '0; m_err[i] = 1'b0; m_ptr[i] = 0; m_k[i] = 1000; m_bcyc[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    logic [NCH-1:0] elig;
    int win;
    int c;
    elig = gc_updt_in & ch_en & ~m_ack[i];
    m_ack[i] = '0;
    if (m_busy[i]) begin
      if (gc_updt_ack) begin
        m_busy[i] = 1'b0;
        m_ack[i][m_id[i]] = 1'b1;
        m_cnt[i] = m_cnt[i] + 32'd1;
        m_ptr[i] = (m_id[i] + 1) % NCH;
        m_k[i] = 1;
      end else begin
        m_bcyc[i]++;
        if (cfg_tmo(i) > 0 && m_bcyc[i] >= cfg_tmo(i)) m_err[i] = 1'b1;
      end
    end else begin
      win = -1;
      if (m_k[i] >= cfg_gap(i)) begin
        for (int j = 0; j < NCH; j++) begin
          c = (cfg_rr(i) != 0) ? (m_ptr[i] + j) % NCH : j;
          if (win < 0 && elig[c]) win = c;
        end
      end
      if (win >= 0) begin
        m_busy[i] = 1'b1;
        m_id[i] = win;
        m_addr[i] = gc_addr_in[win*AW +: AW];
        m_bcyc[i] = 0;
      end else if (m_k[i] < 1000) begin
        m_k[i]++;
      end
    end
  endtask

  task automatic compare_all();
    chk("a_updt", 64'(a_updt),    64'(m_busy[0]));
    chk("a_addr", 64'(a_addr),    64'(m_addr[0]));
    chk("a_id",   64'(a_id),      64'(m_id[0]));
    chk("a_ack",  64'(a_ack_out), 64'(m_ack[0]));
    chk("a_cnt",  64'(a_cnt),     64'(m_cnt[0]));
    chk("a_err",  64'(a_err),     64'(m_err[0]));
    chk("b_updt", 64'(b_updt),    64'(m_busy[1]));
    chk("b_addr", 64'(b_addr),    64'(m_addr[1]));
    chk("b_id",   64'(b_id),      64'(m_id[1]));
    chk("b_ack",  64'(b_ack_out), 64'(m_ack[1]));
    chk("b_cnt",  64'(b_cnt),     64'(m_cnt[1]));
    chk("b_err",  64'(b_err),     64'(m_err[1]));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_reset();
    else for (int i = 0; i < NI; i++) model_step(i);
    #1 compare_all();
  endtask

  task automatic wait_busy_a();
    int n;
    n = 0;
    while (!m_busy[0] && n < 50) begin
      cycle();
      n++;
    end
  endtask

  task automatic pulse_ack();
    gc_updt_ack = 1'b1;
    cycle();
    gc_updt_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    total = 0; bad = 0;
    rst = 1'b0; ch_en = '0; gc_addr_in = '0; gc_updt_in = '0; gc_updt_ack = 1'b0;
    model_reset();
    #1 compare_all();
    repeat (3) cycle();
    rst = 1'b1;
    repeat (20) cycle();

    // Single request on channel 2.
    ch_en = '1;
    gc_addr_in[2*AW +: AW] = 64'h0000_0001_DEAD_0040;
    gc_updt_in = 4'b0100;
    cycle();
    chk("single_updt", 64'(a_updt), 64'd1);
    chk("single_addr", 64'(a_addr), 64'h0000_0001_DEAD_0040);
    chk("single_id",   64'(a_id),   64'd2);
    repeat (4) cycle();
    pulse_ack();
    chk("single_ack", 64'(a_ack_out), 64'b0100);
    chk("single_cnt", 64'(a_cnt),     64'd1);
    cycle();
    chk("single_nogrant_b", 64'(b_updt), 64'd0);
    gc_updt_in = '0;
    repeat (6) cycle();

    // All channels requesting: round-robin order continues from pointer 3.
    gc_updt_in = '1;
    for (int g = 0; g < 8; g++) begin
      wait_busy_a();
      chk("rr_order", 64'(a_id), 64'((3 + g) % NCH));
      repeat (2) cycle();
      pulse_ack();
    end
    chk("rr_cnt", 64'(a_cnt), 64'd9);
    gc_updt_in = '0;
    repeat (8) cycle();

    // Masked channel 1 is never granted.
    ch_en = 4'b1101;
    gc_updt_in = 4'b1010;
    wait_busy_a();
    chk("mask_id", 64'(a_id), 64'd3);
    repeat (2) cycle();
    pulse_ack();
    repeat (4) cycle();
    gc_updt_in = '0;
    ch_en = '1;
    repeat (6) cycle();

    // Idle gap between ack and next grant.
    gc_updt_in = 4'b0011;
    wait_busy_a();
    cycle();
    pulse_ack();
    n = 0;
    while (!a_updt && n < 20) begin
      n++;
      cycle();
    end
    chk("gap_len", 64'(n), 64'(GAP_A));
    cycle();
    pulse_ack();
    gc_updt_in = '0;
    repeat (8) cycle();

    // Ack withheld: timeout flag after TMO edges in BUSY, grant kept.
    gc_updt_in = 4'b0001;
    wait_busy_a();
    n = 0;
    while (!a_err && n < 40) begin
      cycle();
      n++;
    end
    chk("tmo_edges", 64'(n), 64'(TMO_A));
    chk("tmo_updt",  64'(a_updt), 64'd1);
    repeat (3) cycle();
    gc_updt_in = '0;
    pulse_ack();
    chk("tmo_sticky", 64'(a_err), 64'd1);
    repeat (6) cycle();

    // Spurious ack while idle.
    pulse_ack();
    repeat (2) cycle();

    // Reset asserted in the middle of a grant.
    gc_updt_in = 4'b0010;
    wait_busy_a();
    cycle();
    #2 rst = 1'b0;
    #1 model_reset();
    compare_all();
    chk("rst_updt", 64'(a_updt), 64'd0);
    repeat (2) cycle();
    chk("rst_noack", 64'(a_ack_out), 64'd0);
    rst = 1'b1;
    gc_updt_in = '0;
    repeat (4) cycle();

    // Random traffic including spurious acks, dropped requests, mask changes.
    for (int r = 0; r < 1500; r++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 7) == 0) gc_updt_in[c] = ~gc_updt_in[c];
        if ($urandom_range(0, 3) == 0) gc_addr_in[c*AW +: AW] = {$urandom, $urandom};
      end
      if ($urandom_range(0, 19) == 0) ch_en = ($urandom_range(0, 1) == 0) ? NCH'($urandom) : '1;
      gc_updt_ack = ($urandom_range(0, 3) == 0);
      cycle();
    end
    gc_updt_ack = 1'b0;
    repeat (4) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
